// File: rtl/intc_pkg.sv
// intc_pkg: register word offsets, the "no source" id and the gateway state type shared by the interrupt controller
package intc_pkg;
  localparam int RegEnable = 0;
  localparam int RegThreshold = 1;
  localparam int RegClaim = 2;
  localparam int RegComplete = 3;
  localparam int RegPending = 4;
  localparam int RegInservice = 5;
  localparam int RegPrioBase = 6;
  localparam int NoneId = 0;
  typedef enum logic [1:0] {IDLE, PENDING, INSERVICE} gw_state_e;
endpackage

// File: rtl/arilla_bus_if.sv
// arilla_bus_if: single-cycle register bus (sel, we, addr, wdata from the master; combinational rdata from the slave)
interface arilla_bus_if;
  logic sel;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output sel, we, addr, wdata, input rdata);
  modport slave(input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/intc_gateway.sv
// intc_gateway: per-source IDLE/PENDING/INSERVICE gateway; ports clk, rst_n, src, claim_sel, complete_sel, pending, inservice
module intc_gateway
  import intc_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic src,
  input logic claim_sel,
  input logic complete_sel,
  output logic pending,
  output logic inservice
);
  gw_state_e state, state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = src ? PENDING : IDLE;
      PENDING: state_nx = claim_sel ? INSERVICE : PENDING;
      INSERVICE: state_nx = complete_sel ? IDLE : INSERVICE;
      default: state_nx = IDLE;
    endcase
  end
  assign pending = state == PENDING;
  assign inservice = state == INSERVICE;
endmodule

// File: rtl/periph_mem_interface.sv
// periph_mem_interface: decodes a SizeWords register window at BaseAddress; ports bus, hit, wr, word, wdata, rdata
module periph_mem_interface #(
  parameter logic [31:0] BaseAddress = 0,
  parameter int SizeWords = 8,
  parameter int WordBits = $clog2(SizeWords)
) (
  arilla_bus_if.slave bus,
  output logic hit,
  output logic wr,
  output logic [WordBits-1:0] word,
  output logic [31:0] wdata,
  input logic [31:0] rdata
);
  localparam logic [31:0] Span = 32'(SizeWords * 4);
  logic [31:0] off;
  assign off = bus.addr - BaseAddress;
  assign hit = bus.sel && off < Span;
  assign wr = hit && bus.we;
  assign word = off[WordBits+1:2];
  assign wdata = bus.wdata;
  assign bus.rdata = hit ? rdata : '0;
endmodule

// File: rtl/intc.sv
// intc: priority interrupt controller; ports clk, rst_n, src_intr, cpu_irq, bus_interface (arilla register bus), hit
module intc
  import intc_pkg::*;
#(
  parameter logic [31:0] BaseAddress = 0,
  parameter int NumSources = 8,
  parameter int PrioBits = 3
) (
  input logic clk,
  input logic rst_n,
  input logic [NumSources-1:0] src_intr,
  output logic cpu_irq,
  arilla_bus_if.slave bus_interface,
  output logic hit
);
  localparam int SizeWords = 2 ** $clog2(6 + NumSources);
  localparam int WordBits = $clog2(SizeWords);
  logic wr;
  logic [WordBits-1:0] word;
  logic [31:0] wi, wdata, rdata;
  logic [NumSources-1:0] enable, pending, inservice, claim_sel, complete_sel;
  logic [PrioBits-1:0] threshold, best_prio, win_prio;
  logic [PrioBits-1:0] prio [NumSources];
  logic [4:0] claimed, best_id, win_id;
  logic claim_wr, complete_wr, unused_bits;
  periph_mem_interface #(.BaseAddress(BaseAddress), .SizeWords(SizeWords), .WordBits(WordBits)) u_mem (
    .bus(bus_interface), .hit(hit), .wr(wr), .word(word), .wdata(wdata), .rdata(rdata)
  );
  assign wi = 32'(word);
  assign claim_wr = wr && wi == RegClaim;
  assign complete_wr = wr && wi == RegComplete;
  assign unused_bits = ^{wdata, best_prio};
  for (genvar i = 0; i < NumSources; i++) begin : g_gw
    intc_gateway u_gw (
      .clk(clk), .rst_n(rst_n), .src(src_intr[i]),
      .claim_sel(claim_sel[i]), .complete_sel(complete_sel[i]),
      .pending(pending[i]), .inservice(inservice[i])
    );
  end
  // strict '>' keeps the lowest index on priority ties
  always_comb begin
    win_id = 5'(NoneId);
    win_prio = '0;
    claim_sel = '0;
    complete_sel = '0;
    for (int i = 0; i < NumSources; i++) begin
      if (pending[i] && enable[i] && prio[i] > threshold && prio[i] > win_prio) begin
        win_id = 5'(i + 1);
        win_prio = prio[i];
      end
      claim_sel[i] = claim_wr && best_id == 5'(i + 1) && pending[i] && enable[i];
      complete_sel[i] = complete_wr && wdata[4:0] == 5'(i + 1);
    end
  end
  always_comb begin
    rdata = '0;
    case (wi)
      RegEnable: rdata[NumSources-1:0] = enable;
      RegThreshold: rdata[PrioBits-1:0] = threshold;
      RegClaim: rdata[4:0] = claimed;
      RegPending: rdata[NumSources-1:0] = pending;
      RegInservice: rdata[NumSources-1:0] = inservice;
      default: rdata = '0;
    endcase
    for (int i = 0; i < NumSources; i++)
      if (wi == 32'(RegPrioBase + i)) rdata[PrioBits-1:0] = prio[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      enable <= '0;
      threshold <= '0;
      claimed <= '0;
      best_id <= '0;
      best_prio <= '0;
      cpu_irq <= 1'b0;
      for (int i = 0; i < NumSources; i++) prio[i] <= '0;
    end else begin
      best_id <= win_id;
      best_prio <= win_prio;
      cpu_irq <= best_id != 5'(NoneId);
      if (claim_wr) claimed <= |claim_sel ? best_id : 5'(NoneId);
      if (wr && wi == RegEnable) enable <= wdata[NumSources-1:0];
      if (wr && wi == RegThreshold) threshold <= wdata[PrioBits-1:0];
      for (int i = 0; i < NumSources; i++)
        if (wr && wi == 32'(RegPrioBase + i)) prio[i] <= wdata[PrioBits-1:0];
    end
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed self-checking bench for intc
module tb_intc;
  localparam logic [31:0] Base = 32'h40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] src = '0;
  logic cpu_irq, hit;
  logic [31:0] d;
  int total = 0;
  int bad = 0;
  arilla_bus_if bus();
  intc #(.BaseAddress(Base), .NumSources(8), .PrioBits(3)) dut (
    .clk(clk), .rst_n(rst_n), .src_intr(src), .cpu_irq(cpu_irq), .bus_interface(bus), .hit(hit)
  );
  always #50 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input int w, input logic [31:0] v);
    @(negedge clk);
    bus.sel = 1'b1;
    bus.we = 1'b1;
    bus.addr = Base + 32'(w * 4);
    bus.wdata = v;
    @(negedge clk);
    bus.sel = 1'b0;
    bus.we = 1'b0;
  endtask
  task automatic rd_now(input int w, output logic [31:0] v);
    bus.sel = 1'b1;
    bus.we = 1'b0;
    bus.addr = Base + 32'(w * 4);
    #1 v = bus.rdata;
    bus.sel = 1'b0;
  endtask
  task automatic rchk(input string tag, input int w, input logic [31:0] exp);
    logic [31:0] v;
    @(negedge clk);
    rd_now(w, v);
    chk(tag, v, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic [7:0] s);
    @(negedge clk);
    src = s;
    @(negedge clk);
    src = '0;
  endtask
  initial begin
    bus.sel = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    #20;
    chk("rst_irq", 32'(cpu_irq), 0);
    rd_now(0, d);
    chk("rst_enable", d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // basic claim/complete
    wr(8, 3);
    wr(0, 32'h04);
    wr(1, 0);
    pulse(8'h04);
    chk("lat1_irq", 32'(cpu_irq), 0);
    cyc(1);
    chk("lat2_irq", 32'(cpu_irq), 0);
    cyc(1);
    chk("lat3_irq", 32'(cpu_irq), 1);
    rchk("basic_pending", 4, 32'h04);
    bus.sel = 1'b1;
    bus.addr = Base + 32'h3c;
    #1 chk("hit_last", 32'(hit), 1);
    chk("unimpl_read", bus.rdata, 0);
    bus.addr = Base + 32'h40;
    #1 chk("hit_above", 32'(hit), 0);
    bus.addr = Base - 32'h4;
    #1 chk("hit_below", 32'(hit), 0);
    bus.sel = 1'b0;
    wr(2, 0);
    rchk("basic_claim", 2, 3);
    cyc(1);
    chk("basic_irq_drop", 32'(cpu_irq), 0);
    rchk("basic_inservice", 5, 32'h04);
    rchk("basic_pend_clr", 4, 0);
    wr(3, 3);
    rchk("basic_complete", 5, 0);
    // priority and tie
    wr(7, 2);
    wr(11, 5);
    wr(12, 5);
    wr(0, 32'h62);
    pulse(8'h62);
    cyc(3);
    chk("prio_irq", 32'(cpu_irq), 1);
    wr(2, 0);
    rchk("prio_claim1", 2, 6);
    wr(2, 0);
    rchk("prio_claim2", 2, 7);
    wr(2, 0);
    rchk("prio_claim3", 2, 2);
    wr(2, 0);
    rchk("prio_claim4", 2, 0);
    rchk("prio_inservice", 5, 32'h62);
    wr(3, 6);
    wr(3, 7);
    wr(3, 2);
    rchk("prio_all_done", 5, 0);
    // threshold and priority 0
    wr(6, 4);
    wr(0, 32'h09);
    wr(1, 4);
    pulse(8'h09);
    cyc(3);
    chk("thr_irq_low", 32'(cpu_irq), 0);
    rchk("thr_pending", 4, 32'h09);
    wr(1, 3);
    cyc(2);
    chk("thr_irq_high", 32'(cpu_irq), 1);
    wr(2, 0);
    rchk("thr_claim", 2, 1);
    wr(3, 1);
    // level re-pend
    @(negedge clk);
    src = 8'h01;
    cyc(3);
    chk("lvl_irq", 32'(cpu_irq), 1);
    wr(2, 0);
    rchk("lvl_claim", 2, 1);
    cyc(1);
    chk("lvl_irq_drop", 32'(cpu_irq), 0);
    rchk("lvl_pend_held", 4, 32'h08);
    wr(3, 1);
    rchk("lvl_repend", 4, 32'h09);
    cyc(2);
    chk("lvl_irq_again", 32'(cpu_irq), 1);
    src = '0;
    wr(2, 0);
    rchk("lvl_claim2", 2, 1);
    wr(3, 1);
    rchk("lvl_done", 5, 0);
    // bogus complete and empty claim
    pulse(8'h01);
    cyc(2);
    wr(2, 0);
    rchk("bog_claim", 2, 1);
    wr(3, 9);
    wr(3, 2);
    rchk("bog_inservice", 5, 32'h01);
    wr(2, 0);
    rchk("bog_empty_claim", 2, 0);
    rchk("bog_pending", 4, 32'h08);
    rchk("bog_inservice2", 5, 32'h01);
    wr(3, 1);
    // async reset mid-operation
    wr(10, 6);
    wr(0, 32'h14);
    wr(1, 0);
    pulse(8'h10);
    cyc(3);
    wr(2, 0);
    rchk("ar_claim", 2, 5);
    pulse(8'h04);
    cyc(3);
    chk("ar_irq_before", 32'(cpu_irq), 1);
    rchk("ar_pending_before", 4, 32'h0c);
    rchk("ar_inservice_before", 5, 32'h10);
    @(posedge clk);
    #10 rst_n = 1'b0;
    #1 chk("ar_irq", 32'(cpu_irq), 0);
    rd_now(4, d);
    chk("ar_pending", d, 0);
    rd_now(5, d);
    chk("ar_inservice", d, 0);
    rd_now(0, d);
    chk("ar_enable", d, 0);
    rd_now(2, d);
    chk("ar_claimed", d, 0);
    for (int i = 0; i < 8; i++) begin
      rd_now(6 + i, d);
      chk($sformatf("ar_prio%0d", i), d, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    chk("ar_irq_after", 32'(cpu_irq), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
